// File: rtl/cache_meta_array_nway.sv
// N-way set-associative cache metadata store: tag/valid/dirty per way, tag compare,
// tree-PLRU victim selection and a sequenced flush with optional dirty-line writeback.
module cache_meta_array_nway #(
  parameter int WAYS     = 4,
  parameter int SETS     = 64,
  parameter int TAG_W    = 23,
  parameter bit FLUSH_WB = 1'b1,
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int IDX_W   = $clog2(SETS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic [IDX_W-1:0]       rd_idx,
  input  logic [TAG_W-1:0]       rd_tag,
  output logic                   rsp_valid,
  output logic [WAYS*TAG_W-1:0]  rsp_tags,
  output logic [WAYS-1:0]        rsp_valids,
  output logic [WAYS-1:0]        rsp_dirtys,
  output logic                   rsp_hit,
  output logic [WAY_W-1:0]       rsp_hitway,
  output logic [WAY_W-1:0]       rsp_victim,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WAY_W-1:0]       wr_way,
  input  logic                   wr_valid,
  input  logic                   wr_dirty,
  input  logic [TAG_W-1:0]       wr_tag,
  input  logic                   flush,
  output logic                   busy,
  output logic                   flush_done,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [IDX_W-1:0]       wb_idx,
  output logic [WAY_W-1:0]       wb_way,
  output logic [TAG_W-1:0]       wb_tag
);

  localparam int LVL    = $clog2(WAYS);
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [TAG_W-1:0]  tags   [SETS][WAYS];
  logic [WAYS-1:0]   valids [SETS];
  logic [WAYS-1:0]   dirtys [SETS];
  logic [PLRU_W-1:0] plru   [SETS];

  logic [1:0]        state;
  logic [IDX_W-1:0]  scan_idx;
  logic [WAY_W-1:0]  scan_way;
  logic [IDX_W-1:0]  rsp_idx;

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half);
  // a node bit of 1 steers the victim toward the upper half.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] p,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] r;
    logic [WAY_W-1:0]  sh;
    logic              dir;
    logic              nb;
    int                node;
    r    = p;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      sh   = way >> (LVL - 1 - l);
      dir  = sh[0];
      nb   = ~dir;
      r    = (r & ~(PLRU_W'(1) << node)) | (PLRU_W'(nb) << node);
      node = 2 * node + 1 + int'(dir);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] p);
    logic [WAY_W-1:0]  v;
    logic [PLRU_W-1:0] sh;
    logic              b;
    int                node;
    v    = '0;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      sh   = p >> node;
      b    = sh[0];
      v    = (v << 1) | WAY_W'(b);
      node = 2 * node + 1 + int'(b);
    end
    return v;
  endfunction

  logic                  rd_acc;
  logic                  wr_acc;
  logic                  touch_hit;
  logic [WAYS*TAG_W-1:0] rd_tags;
  logic [WAYS-1:0]       rd_valids;
  logic [WAYS-1:0]       rd_dirtys;
  logic [TAG_W-1:0]      tag_w;
  logic                  rd_hit;
  logic [WAY_W-1:0]      rd_hitway;
  logic [WAY_W-1:0]      rd_victim;
  logic [PLRU_W-1:0]     plru_rd;
  logic [PLRU_W-1:0]     plru_wr;
  logic [WAYS-1:0]       scan_vd;
  logic [TAG_W-1:0]      scan_tag;
  logic                  scan_wb;
  logic                  scan_last;
  logic                  scan_way_wrap;

  assign busy       = (state != S_IDLE);
  assign flush_done = (state == S_DONE);
  assign wb_valid   = (state == S_WB);
  assign wb_idx     = wb_valid ? scan_idx : '0;
  assign wb_way     = wb_valid ? scan_way : '0;
  assign wb_tag     = wb_valid ? scan_tag : '0;

  assign rd_acc        = rd_en && !busy;
  assign wr_acc        = wr_en && !busy;
  assign touch_hit     = rsp_valid && rsp_hit;
  assign scan_way_wrap = (scan_way == WAY_W'(WAYS - 1));
  assign scan_last     = scan_way_wrap && (scan_idx == IDX_W'(SETS - 1));

  // Lookup sees the set as it will be after this edge: same-cycle write and the pending
  // hit touch from the previous response are folded in before compare and victim pick.
  always_comb begin
    rd_tags   = '0;
    rd_valids = valids[rd_idx];
    rd_dirtys = dirtys[rd_idx];
    rd_hit    = 1'b0;
    rd_hitway = '0;
    tag_w     = '0;
    for (int w = 0; w < WAYS; w++) begin
      tag_w = tags[rd_idx][w];
      if (wr_acc && wr_idx == rd_idx && wr_way == WAY_W'(w)) begin
        tag_w        = wr_tag;
        rd_valids[w] = wr_valid;
        rd_dirtys[w] = wr_dirty;
      end
      rd_tags[w*TAG_W +: TAG_W] = tag_w;
      if (!rd_hit && rd_valids[w] && tag_w == rd_tag) begin
        rd_hit    = 1'b1;
        rd_hitway = WAY_W'(w);
      end
    end

    plru_wr = plru[wr_idx];
    if (touch_hit && rsp_idx == wr_idx) plru_wr = plru_touch(plru_wr, rsp_hitway);
    plru_rd = plru[rd_idx];
    if (touch_hit && rsp_idx == rd_idx) plru_rd = plru_touch(plru_rd, rsp_hitway);
    if (wr_acc && wr_valid && wr_idx == rd_idx) plru_rd = plru_touch(plru_rd, wr_way);
    rd_victim = plru_victim(plru_rd);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!rd_valids[w]) rd_victim = WAY_W'(w);
    end
  end

  always_comb begin
    scan_tag = '0;
    scan_vd  = (valids[scan_idx] & dirtys[scan_idx]) >> scan_way;
    for (int w = 0; w < WAYS; w++) begin
      if (scan_way == WAY_W'(w)) scan_tag = tags[scan_idx][w];
    end
    scan_wb = FLUSH_WB && scan_vd[0];
  end

  always_ff @(posedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      if (wr_acc && wr_way == WAY_W'(w)) tags[wr_idx][w] <= wr_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      scan_idx   <= '0;
      scan_way   <= '0;
      rsp_valid  <= 1'b0;
      rsp_tags   <= '0;
      rsp_valids <= '0;
      rsp_dirtys <= '0;
      rsp_hit    <= 1'b0;
      rsp_hitway <= '0;
      rsp_victim <= '0;
      rsp_idx    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valids[s] <= '0;
        dirtys[s] <= '0;
        plru[s]   <= '0;
      end
    end else begin
      // Response stage: registered lookup result.
      rsp_valid <= rd_acc;
      if (rd_acc) begin
        rsp_tags   <= rd_tags;
        rsp_valids <= rd_valids;
        rsp_dirtys <= rd_dirtys;
        rsp_hit    <= rd_hit;
        rsp_hitway <= rd_hitway;
        rsp_victim <= rd_victim;
        rsp_idx    <= rd_idx;
      end

      // A write touch to the same set overrides the hit touch (it already includes it).
      if (touch_hit) plru[rsp_idx] <= plru_touch(plru[rsp_idx], rsp_hitway);
      if (wr_acc) begin
        for (int w = 0; w < WAYS; w++) begin
          if (wr_way == WAY_W'(w)) begin
            valids[wr_idx][w] <= wr_valid;
            dirtys[wr_idx][w] <= wr_dirty;
          end
        end
        if (wr_valid) plru[wr_idx] <= plru_touch(plru_wr, wr_way);
      end

      case (state)
        S_IDLE: begin
          if (flush) begin
            state    <= S_SCAN;
            scan_idx <= '0;
            scan_way <= '0;
          end
        end
        S_SCAN, S_WB: begin
          if ((state == S_SCAN && !scan_wb) || (state == S_WB && wb_ready)) begin
            for (int w = 0; w < WAYS; w++) begin
              if (scan_way == WAY_W'(w)) begin
                valids[scan_idx][w] <= 1'b0;
                dirtys[scan_idx][w] <= 1'b0;
              end
            end
            scan_way <= scan_way_wrap ? '0 : scan_way + 1'b1;
            if (scan_way_wrap) scan_idx <= scan_idx + 1'b1;
            state <= scan_last ? S_DONE : S_SCAN;
          end else if (state == S_SCAN) begin
            state <= S_WB;
          end
        end
        default: begin
          for (int s = 0; s < SETS; s++) plru[s] <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_meta_array_nway.sv
// Scoreboarded bench for cache_meta_array_nway: directed cases, randomized traffic and
// flush/writeback sequences against a behavioural set/way model.
module tb_cache_meta_array_nway;

  localparam int WAYS  = 4;
  localparam int SETS  = 64;
  localparam int TAG_W = 23;
  localparam int WAY_W = 2;
  localparam int IDX_W = 6;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  rd_en;
  logic [IDX_W-1:0]      rd_idx;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rsp_valid;
  logic [WAYS*TAG_W-1:0] rsp_tags;
  logic [WAYS-1:0]       rsp_valids;
  logic [WAYS-1:0]       rsp_dirtys;
  logic                  rsp_hit;
  logic [WAY_W-1:0]      rsp_hitway;
  logic [WAY_W-1:0]      rsp_victim;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [WAY_W-1:0]      wr_way;
  logic                  wr_valid;
  logic                  wr_dirty;
  logic [TAG_W-1:0]      wr_tag;
  logic                  flush;
  logic                  busy;
  logic                  flush_done;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [IDX_W-1:0]      wb_idx;
  logic [WAY_W-1:0]      wb_way;
  logic [TAG_W-1:0]      wb_tag;

  cache_meta_array_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .FLUSH_WB(1'b1)) dut (
    .clock(clock), .reset(reset),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_tag(rd_tag),
    .rsp_valid(rsp_valid), .rsp_tags(rsp_tags), .rsp_valids(rsp_valids),
    .rsp_dirtys(rsp_dirtys), .rsp_hit(rsp_hit), .rsp_hitway(rsp_hitway),
    .rsp_victim(rsp_victim),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_way(wr_way), .wr_valid(wr_valid),
    .wr_dirty(wr_dirty), .wr_tag(wr_tag),
    .flush(flush), .busy(busy), .flush_done(flush_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_idx(wb_idx), .wb_way(wb_way),
    .wb_tag(wb_tag)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [WAYS*TAG_W-1:0] tags;
    logic [WAYS-1:0]       known;
    logic [WAYS-1:0]       valids;
    logic [WAYS-1:0]       dirtys;
    logic                  hit;
    logic [WAY_W-1:0]      hitway;
    logic [WAY_W-1:0]      victim;
  } rsp_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAY_W-1:0] way;
    logic [TAG_W-1:0] tag;
  } wb_t;

  rsp_t exp_q[$];
  wb_t  wb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: per-entry state plus one steering bit per tree node (1 = victim in upper half).
  bit               m_val   [SETS][WAYS];
  bit               m_dirty [SETS][WAYS];
  bit               m_known [SETS][WAYS];
  bit               m_nb    [SETS][WAYS];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];
  bit               pend;
  int               pend_idx;
  int               pend_way;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void m_touch(input int s, input int w);
    int lo = 0, hi = WAYS, n = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin m_nb[s][n] = 1'b1; hi = mid; n = 2 * n + 1; end
      else         begin m_nb[s][n] = 1'b0; lo = mid; n = 2 * n + 2; end
    end
  endfunction

  function automatic int m_victim(input int s);
    int lo = 0, hi = WAYS, n = 0, mid;
    for (int w = 0; w < WAYS; w++) if (!m_val[s][w]) return w;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_nb[s][n]) begin lo = mid; n = 2 * n + 2; end
      else            begin hi = mid; n = 2 * n + 1; end
    end
    return lo;
  endfunction

  function automatic void m_clear(input bit whole_reset);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_val[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_nb[s][w] = 1'b0;
        if (whole_reset && s < 0) m_known[s][w] = 1'b0;
      end
    pend = 1'b0;
  endfunction

  function automatic void model_edge(input bit rd, input int ridx, input logic [TAG_W-1:0] rtag,
                                     input bit wr, input int widx, input int wway,
                                     input bit wv, input bit wd, input logic [TAG_W-1:0] wtag);
    rsp_t e;
    if (pend) m_touch(pend_idx, pend_way);
    pend = 1'b0;
    if (wr) begin
      m_tag[widx][wway]   = wtag;
      m_known[widx][wway] = 1'b1;
      m_val[widx][wway]   = wv;
      m_dirty[widx][wway] = wd;
      if (wv) m_touch(widx, wway);
    end
    if (rd) begin
      e = '0;
      for (int w = 0; w < WAYS; w++) begin
        e.tags[w*TAG_W +: TAG_W] = m_tag[ridx][w];
        e.known[w]  = m_known[ridx][w];
        e.valids[w] = m_val[ridx][w];
        e.dirtys[w] = m_dirty[ridx][w];
        if (!e.hit && m_val[ridx][w] && m_tag[ridx][w] == rtag) begin
          e.hit = 1'b1; e.hitway = WAY_W'(w);
        end
      end
      e.victim = WAY_W'(m_victim(ridx));
      exp_q.push_back(e);
      if (e.hit) begin pend = 1'b1; pend_idx = ridx; pend_way = int'(e.hitway); end
    end
  endfunction

  // Response monitor: every presented response must match the oldest expectation.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clock);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: rsp_valid=1 with valids 0x%0h, none expected", rsp_valids);
        end else begin
          e = exp_q.pop_front();
          check("rsp_valids", rsp_valids, e.valids);
          check("rsp_dirtys", rsp_dirtys, e.dirtys);
          check("rsp_hit", rsp_hit, e.hit);
          check("rsp_victim", rsp_victim, e.victim);
          if (e.hit) check("rsp_hitway", rsp_hitway, e.hitway);
          for (int w = 0; w < WAYS; w++)
            if (e.known[w]) check($sformatf("rsp_tag%0d", w), rsp_tags[w*TAG_W +: TAG_W],
                                  e.tags[w*TAG_W +: TAG_W]);
        end
      end
    end
  end

  task automatic step(input bit rd, input int ridx, input logic [TAG_W-1:0] rtag,
                      input bit wr, input int widx, input int wway,
                      input bit wv, input bit wd, input logic [TAG_W-1:0] wtag);
    rd_en = rd; rd_idx = IDX_W'(ridx); rd_tag = rtag;
    wr_en = wr; wr_idx = IDX_W'(widx); wr_way = WAY_W'(wway);
    wr_valid = wv; wr_dirty = wd; wr_tag = wtag;
    model_edge(rd, ridx, rtag, wr, widx, wway, wv, wd, wtag);
    @(posedge clock); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic lookup(input int idx, input logic [TAG_W-1:0] tag);
    step(1'b1, idx, tag, 1'b0, 0, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic write(input int idx, input int way, input bit v, input bit d, input logic [TAG_W-1:0] tag);
    step(1'b0, 0, '0, 1'b1, idx, way, v, d, tag);
  endtask

  task automatic run_flush(input bit rand_ready, input int hold, input bit noise, input int exp_edges);
    int  edges, waited;
    bit  offered;
    wb_t f;
    if (pend) m_touch(pend_idx, pend_way);
    pend = 1'b0;
    wb_q.delete();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_val[s][w] && m_dirty[s][w]) begin
          f.idx = IDX_W'(s); f.way = WAY_W'(w); f.tag = m_tag[s][w];
          wb_q.push_back(f);
        end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    edges = 1; waited = 0;
    check("flush_busy", busy, 1);
    while (!flush_done && edges < 5000) begin
      offered = wb_valid;
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_extra: offered idx %0d way %0d, none expected", wb_idx, wb_way);
        end else begin
          check("wb_idx", wb_idx, wb_q[0].idx);
          check("wb_way", wb_way, wb_q[0].way);
          check("wb_tag", wb_tag, wb_q[0].tag);
        end
        wb_ready = rand_ready ? 1'($urandom_range(0, 1)) : (waited >= hold);
        waited++;
      end else begin
        wb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (noise) begin
        rd_en = 1'($urandom_range(0, 1)); rd_idx = 4; rd_tag = 'h77;
        wr_en = 1'($urandom_range(0, 1)); wr_idx = 4; wr_way = 0;
        wr_valid = 1'b1; wr_dirty = 1'b1; wr_tag = 'h77;
      end
      @(posedge clock); #1;
      edges++;
      if (offered && wb_ready) begin
        if (wb_q.size() > 0) void'(wb_q.pop_front());
        waited = 0;
      end
    end
    rd_en = 1'b0; wr_en = 1'b0; wb_ready = 1'b0;
    if (!flush_done) begin
      checks++; errors++;
      $display("FAIL flush_timeout: no flush_done after %0d edges, expected completion", edges);
    end else if (exp_edges > 0) begin
      check("flush_edges", edges, exp_edges);
    end
    check("wb_all_offered", wb_q.size(), 0);
    @(posedge clock); #1;
    check("flush_done_pulse", flush_done, 0);
    check("idle_after_flush", busy, 0);
    m_clear(1'b0);
  endtask

  initial begin
    int n;
    reset = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    rd_en = 1'b0; rd_idx = '0; rd_tag = '0;
    wr_en = 1'b0; wr_idx = '0; wr_way = '0; wr_valid = 1'b0; wr_dirty = 1'b0; wr_tag = '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_known[s][w] = 1'b0;
    m_clear(1'b1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_hit", rsp_hit, 0);
    check("reset_busy", busy, 0);
    check("reset_flush_done", flush_done, 0);
    check("reset_wb_valid", wb_valid, 0);
    check("reset_wb_tag", wb_tag, 0);

    lookup(5, 'h0);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_valids", rsp_valids, 0);
    check("t1_victim", rsp_victim, 0);

    for (int w = 0; w < WAYS; w++) write(3, w, 1'b1, 1'b0, TAG_W'('h10 + w));
    lookup(3, 'h12);
    check("t2_hit", rsp_hit, 1);
    check("t2_hitway", rsp_hitway, 2);
    lookup(3, 'h99);
    check("t2_miss", rsp_hit, 0);

    for (int w = 0; w < WAYS; w++) write(7, w, 1'b1, 1'b0, TAG_W'('h70 + w));
    lookup(7, 'h70);
    check("t3_fill_victim", rsp_victim, 0);
    check("t3_hitway0", rsp_hitway, 0);
    lookup(7, 'h1);
    check("t3_victim_after_hit", rsp_victim, 2);
    step(1'b1, 7, 'h55, 1'b1, 7, 1, 1'b1, 1'b0, 'h55);
    check("t3_bypass_tag1", rsp_tags[1*TAG_W +: TAG_W], 'h55);
    check("t3_bypass_hitway", rsp_hitway, 1);

    run_flush(1'b0, 0, 1'b1, SETS * WAYS + 1);
    lookup(4, 'h77);
    lookup(3, 'h12);

    write(2, 1, 1'b1, 1'b1, 'hAB);
    write(9, 3, 1'b1, 1'b1, 'hCD);
    run_flush(1'b0, 5, 1'b0, 0);
    lookup(2, 'hAB);
    lookup(9, 'hCD);

    for (int i = 0; i < 400; i++) begin
      int idx;
      idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, SETS - 1)) : int'($urandom_range(0, 7));
      step(1'($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)), TAG_W'('h100 + $urandom_range(0, 3)),
           1'($urandom_range(0, 9) < 4), idx, int'($urandom_range(0, WAYS - 1)),
           1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), TAG_W'('h100 + $urandom_range(0, 3)));
    end
    run_flush(1'b1, 0, 1'b0, 0);
    for (int s = 0; s < 8; s++) lookup(s, 'h100);

    write(5, 2, 1'b1, 1'b1, 'h3C);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    n = 0;
    while (!wb_valid && n < 1000) begin @(posedge clock); #1; n++; end
    check("t6_in_wb", wb_valid, 1);
    check("t6_wb_tag", wb_tag, 'h3C);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("t6_wb_valid", wb_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_flush_done", flush_done, 0);
    m_clear(1'b0);
    lookup(5, 'h3C);
    check("t6_lookup_valids", rsp_valids, 0);
    lookup(3, 'h12);

    repeat (3) @(posedge clock);
    #1;
    check("rsp_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
